// File: rtl/cpu_reset_sequencer_if.sv
// Signal bundle between the CPU reset sequencer and its surroundings.
// master: the system side (PLL lock, button, CPU watchdog kick).
// slave:  the sequencer itself.
interface cpu_reset_sequencer_if;
  logic       pll_locked;
  logic       btn_reset;
  logic       wdt_kick;
  logic       cpu_rst;
  logic [1:0] seq_state;
  logic [7:0] reset_cnt;
  logic       wdt_fired;

  modport master (
    output pll_locked, btn_reset, wdt_kick,
    input  cpu_rst, seq_state, reset_cnt, wdt_fired
  );

  modport slave (
    input  pll_locked, btn_reset, wdt_kick,
    output cpu_rst, seq_state, reset_cnt, wdt_fired
  );
endinterface

// File: rtl/cpu_reset_sequencer.sv
// CPU reset sequencer: waits for a filtered PLL lock, holds the CPU in reset
// for HOLD_CYCLES, then releases it. A button or (optionally) a watchdog
// expiry re-enters HOLD; losing lock always returns to WAIT_LOCK.
// Optional watchdog is compiled in with macro RST_SEQ_WDT_EN.
//
// state      | meaning
// WAIT_LOCK  | cpu_rst high, counting consecutive synchronized lock-high cycles
// HOLD       | cpu_rst high, counting HOLD_CYCLES before release
// RUN        | cpu_rst low, CPU running; button / watchdog / lock loss leave
module cpu_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned WDT_CYCLES  = 1_000_000
) (
  input logic                  clk,
  input logic                  rst_n,
  cpu_reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  FILT_LAST = 8'(LOCK_FILTER - 1);

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [7:0]  filt_q, filt_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        cpu_rst_q;
  logic        wdt_expire;
  logic        lock;

  assign lock = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, filter, hold-timer and reset-count logic
  always_comb begin
    state_d = state_q;
    filt_d  = '0;
    hold_d  = hold_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock) begin
          if (filt_q == FILT_LAST) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            filt_d = filt_q + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
        end else if (bus.btn_reset) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
        end else if (bus.btn_reset || wdt_expire) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          rcnt_d  = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // State and registered outputs; cpu_rst follows the next state so it
  // changes on the same edge as seq_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_LOCK;
      filt_q    <= '0;
      hold_q    <= '0;
      rcnt_q    <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      rcnt_q    <= rcnt_d;
      cpu_rst_q <= (state_d != ST_RUN);
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam logic [23:0] WDT_LAST = 24'(WDT_CYCLES - 1);

  logic [23:0] wdt_q, wdt_d;
  logic        wdt_fired_q;

  // A kick in the terminal cycle still rescues the CPU
  assign wdt_expire = (state_q == ST_RUN) && !bus.wdt_kick && (wdt_q == WDT_LAST);

  // Watchdog count: cleared on RUN entry and on kick, frozen outside RUN
  always_comb begin
    wdt_d = wdt_q;
    if (state_q != ST_RUN) begin
      if (state_d == ST_RUN) wdt_d = '0;
    end else if (bus.wdt_kick) begin
      wdt_d = '0;
    end else begin
      wdt_d = wdt_q + 24'd1;
    end
  end

  // Watchdog counter and fire pulse (only when expiry actually wins priority)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q       <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_q       <= wdt_d;
      wdt_fired_q <= wdt_expire && lock && !bus.btn_reset;
    end
  end

  assign bus.wdt_fired = wdt_fired_q;
`else
  // Keep the kick port and timeout parameter referenced when no watchdog exists
  logic unused_wdt;
  assign unused_wdt    = bus.wdt_kick | (WDT_CYCLES == 0);
  assign wdt_expire    = 1'b0;
  assign bus.wdt_fired = 1'b0;
`endif

  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.seq_state = (state_q == 2'b11) ? 2'b00 : state_q;
  assign bus.reset_cnt = rcnt_q;

endmodule

// File: doc/cpu_reset_sequencer.md
CPU_RESET_SEQUENCER -- requirements
Module: cpu_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles cpu_rst stays asserted in HOLD; legal range 1..65535.
REQ-002 Parameter LOCK_FILTER, default 8: consecutive synchronized pll_locked-high cycles required before leaving WAIT_LOCK; legal range 1..255.
REQ-003 Parameter WDT_CYCLES, default 1_000_000: watchdog timeout in cycles; legal range 2..2^24-1.
REQ-004 clk  in  1  CPU clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is sampled on clk.
REQ-006 pll_locked  in  1  clock-wizard lock, asynchronous to clk.
REQ-007 btn_reset  in  1  one-cycle pulse from the debounced button/switch logic requesting a CPU reset.
REQ-008 wdt_kick  in  1  one-cycle pulse from CPU software servicing the watchdog.
REQ-009 cpu_rst  out  1  registered, active-high reset driven to the CPU rst port.
REQ-010 seq_state  out  2  current state: 0 WAIT_LOCK, 1 HOLD, 2 RUN; 3 is never driven.
REQ-011 reset_cnt  out  8  saturating count of HOLD entries made from RUN.
REQ-012 wdt_fired  out  1  one-cycle pulse when the watchdog expires.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; all references to lock below mean the synchronized value.
REQ-014 In WAIT_LOCK, a filter counter SHALL increment each cycle lock is high and clear on any cycle lock is low; on the cycle it reaches LOCK_FILTER, the next state SHALL be HOLD.
REQ-015 On HOLD entry, the hold counter SHALL load 0, increment each cycle, and transition to RUN on the cycle it equals HOLD_CYCLES-1, so that cpu_rst is high for exactly HOLD_CYCLES cycles in HOLD.
REQ-016 cpu_rst SHALL be 1 in WAIT_LOCK and HOLD and 0 in RUN, registered so it changes on the same edge as seq_state.
REQ-017 In RUN, btn_reset=1 SHALL move to HOLD on the next edge and increment reset_cnt.
REQ-018 In HOLD, btn_reset=1 SHALL restart the hold counter at 0 without incrementing reset_cnt.
REQ-019 In WAIT_LOCK, btn_reset SHALL be ignored.
REQ-020 In HOLD or RUN, lock=0 SHALL move to WAIT_LOCK on the next edge with the filter counter cleared; this takes priority over btn_reset and the watchdog.
REQ-021 Priority in RUN SHALL be: lock loss > btn_reset > watchdog expiry.
REQ-022 reset_cnt SHALL saturate at 255 and never wrap.
REQ-023 seq_state SHALL never hold the value 3; an illegal internal encoding SHALL recover to WAIT_LOCK on the next edge.

Reset
REQ-024 While rst_n=0: state=WAIT_LOCK, cpu_rst=1, seq_state=0, reset_cnt=0, wdt_fired=0, all counters and synchronizer flops at 0.
REQ-025 rst_n asserted mid-HOLD or mid-RUN SHALL force cpu_rst=1 asynchronously, without waiting for a clk edge.

Configuration
REQ-026 Macro RST_SEQ_WDT_EN, when defined, SHALL compile in the watchdog:
- 24-bit counter clears on RUN entry and on wdt_kick, and increments each cycle in RUN.
- On reaching WDT_CYCLES-1, the block SHALL pulse wdt_fired for one cycle, enter HOLD, and increment reset_cnt.
- The counter is frozen outside RUN.
REQ-027 When RST_SEQ_WDT_EN is undefined:
- no watchdog logic SHALL exist;
- wdt_kick SHALL be ignored;
- wdt_fired SHALL be tied to 0;
- all ports remain present.

Verification (HOLD_CYCLES=4, LOCK_FILTER=3, WDT_CYCLES=10)
REQ-028 Power-up: release rst_n, then hold pll_locked=1. Required: seq_state goes 0->1 five cycles after pll_locked is sampled high (2 synchronizer + 3 filter), cpu_rst stays high 4 further cycles, then cpu_rst=0 and seq_state=2.
REQ-029 Lock glitch: pll_locked high 2 cycles, low 1 cycle, then high. Required: filter restarts and HOLD is entered only after 3 consecutive high synchronized samples.
REQ-030 Button in RUN, then again in HOLD:
- btn_reset pulse in RUN gives cpu_rst=1 next cycle and reset_cnt 0->1.
- A second pulse on the 3rd HOLD cycle extends HOLD to 3+4 cycles; reset_cnt stays 1.
REQ-031 Lock loss in RUN with simultaneous btn_reset. Required: seq_state=0, cpu_rst=1, reset_cnt unchanged.
REQ-032 With RST_SEQ_WDT_EN:
- no kick for 10 RUN cycles gives a wdt_fired pulse, HOLD entry, and reset_cnt+1;
- a kick every 5 cycles never fires.
- Without the macro, 1000 RUN cycles with no kick give wdt_fired=0.
REQ-033 Saturation and async reset: 260 btn_reset events leave reset_cnt=255. rst_n dropped mid-RUN between clk edges sets cpu_rst=1 immediately and reset_cnt=0.
